// File: rtl/dpwm_interleaved.sv
// N-phase interleaved digital PWM with dead-time.
// A master counter runs over a shadowed period. Each phase sees the master
// count shifted by k*ph_step (mod period). The on-time of each phase is
// latched and clamped at that phase's own period start. c1/c2 are registered
// and lag the counter compare by one cycle.
module dpwm_interleaved #(
  parameter int CNT_W      = 11,
  parameter int DT_W       = 5,
  parameter int N_PH       = 2,
  parameter int DEFAULT_TS = 1000
) (
  input  logic                   i_clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [CNT_W-1:0]       i_ts,
  input  logic [CNT_W-1:0]       i_ph_step,
  input  logic [N_PH*CNT_W-1:0]  i_ton,
  input  logic [DT_W-1:0]        i_dt1,
  input  logic [DT_W-1:0]        i_dt2,
  output logic                   o_cntrl_ts_last,
  output logic                   o_running,
  output logic [N_PH-1:0]        o_clamped,
  output logic [N_PH-1:0]        c1,
  output logic [N_PH-1:0]        c2
);

  localparam int OFF_W = CNT_W + 3;  // holds k*ph_step for k <= 7
  localparam int CW    = CNT_W + 2;  // compare width, no wrap

  typedef enum logic [1:0] {IDLE, ARMED, RUN, STOP} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   m_q, ts_sh_q;
  logic [DT_W-1:0]    dt1_sh_q, dt2_sh_q;
  logic [OFF_W-1:0]   off_q [N_PH];
  logic [CNT_W-1:0]   ton_q [N_PH];
  logic [N_PH-1:0]    clamped_q, c1_q, c2_q;

  logic               wrap, settled, run_d;
  logic signed [CW-1:0] lim;
  logic [CW-1:0]      dt1_x, dt2_x;
  logic [CNT_W:0]     sum    [N_PH];
  logic [CNT_W-1:0]   cnt    [N_PH];
  logic [CNT_W-1:0]   ton_in [N_PH];
  logic [CNT_W-1:0]   ton_new[N_PH];
  logic [CW-1:0]      on_hi  [N_PH];
  logic [CW-1:0]      lo_on  [N_PH];
  logic [N_PH-1:0]    clamp_new, latch, c1_d, c2_d;

  assign wrap            = (m_q >= ts_sh_q - CNT_W'(1));
  assign o_cntrl_ts_last = (m_q == ts_sh_q - CNT_W'(1));
  assign o_running       = (state_q == RUN);
  assign o_clamped       = clamped_q;
  assign c1              = c1_q;
  assign c2              = c2_q;

  assign dt1_x = {{(CW-DT_W){1'b0}}, dt1_sh_q};
  assign dt2_x = {{(CW-DT_W){1'b0}}, dt2_sh_q};
  assign lim   = $signed({2'b00, ts_sh_q}) - $signed(dt1_x) - $signed(dt2_x);

  // Run qualifier for the outputs registered at this edge: follows the next FSM state
  always_comb begin
    case (state_q)
      ARMED:   run_d = enable & o_cntrl_ts_last;
      RUN:     run_d = enable;
      default: run_d = 1'b0;
    endcase
  end

  // Phase counts, clamped on-times and gate compares
  always_comb begin
    settled = 1'b1;
    for (int unsigned k = 0; k < N_PH; k++) begin
      if (off_q[k] >= {3'b000, ts_sh_q}) settled = 1'b0;
      // offsets are fully reduced once settled, so one conditional subtract wraps the sum
      sum[k]    = {1'b0, m_q} + {1'b0, off_q[k][CNT_W-1:0]};
      cnt[k]    = (sum[k] >= {1'b0, ts_sh_q}) ? CNT_W'(sum[k] - {1'b0, ts_sh_q})
                                              : sum[k][CNT_W-1:0];
      ton_in[k] = i_ton[k*CNT_W +: CNT_W];
      if (lim[CW-1])
        ton_new[k] = '0;
      else if ({2'b00, ton_in[k]} > $unsigned(lim))
        ton_new[k] = lim[CNT_W-1:0];
      else
        ton_new[k] = ton_in[k];
      clamp_new[k] = (ton_new[k] != ton_in[k]);
    end
    for (int unsigned k = 0; k < N_PH; k++) begin
      latch[k] = settled & (cnt[k] == '0);
      // at the phase's own period start the freshly latched value already applies
      on_hi[k] = dt1_x + (latch[k] ? {2'b00, ton_new[k]} : {2'b00, ton_q[k]});
      lo_on[k] = on_hi[k] + dt2_x;
      c1_d[k]  = run_d & settled & ({2'b00, cnt[k]} >= dt1_x) & ({2'b00, cnt[k]} < on_hi[k]);
      c2_d[k]  = run_d & settled & ({2'b00, cnt[k]} >= lo_on[k]);
    end
  end

  // Master counter, period-boundary shadow load and offset reduction
  always_ff @(posedge i_clk) begin
    if (reset) begin
      m_q      <= '0;
      ts_sh_q  <= CNT_W'(DEFAULT_TS);
      dt1_sh_q <= '0;
      dt2_sh_q <= '0;
      for (int unsigned k = 0; k < N_PH; k++) off_q[k] <= '0;
    end else if (wrap) begin
      m_q      <= '0;
      ts_sh_q  <= (i_ts < CNT_W'(4)) ? CNT_W'(4) : i_ts;
      dt1_sh_q <= i_dt1;
      dt2_sh_q <= i_dt2;
      for (int unsigned k = 0; k < N_PH; k++)
        off_q[k] <= OFF_W'(k) * {3'b000, i_ph_step};
    end else begin
      m_q <= m_q + CNT_W'(1);
      for (int unsigned k = 0; k < N_PH; k++)
        if (off_q[k] >= {3'b000, ts_sh_q}) off_q[k] <= off_q[k] - {3'b000, ts_sh_q};
    end
  end

  // Per-phase on-time latch and registered gate outputs
  always_ff @(posedge i_clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < N_PH; k++) ton_q[k] <= '0;
      clamped_q <= '0;
      c1_q      <= '0;
      c2_q      <= '0;
    end else begin
      for (int unsigned k = 0; k < N_PH; k++) begin
        if (latch[k]) begin
          ton_q[k]     <= ton_new[k];
          clamped_q[k] <= clamp_new[k];
        end
      end
      c1_q <= c1_d;
      c2_q <= c2_d;
    end
  end

  // Enable start/stop sequencing; RUN always begins at m=0
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (enable) state_q <= ARMED;
        ARMED:   if (!enable) state_q <= IDLE;
                 else if (o_cntrl_ts_last) state_q <= RUN;
        RUN:     if (!enable) state_q <= STOP;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
